// File: rtl/filter_sched_pkg.sv
// Shared types and width helpers for the filter row scheduler and filter buffer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package filter_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_PRELOAD    = 3'd1,
    S_LOAD       = 3'd2,
    S_WAIT_VALID = 3'd3,
    S_HOLD       = 3'd4,
    S_DONE       = 3'd5
  } state_t;

  // Width of an index over n entries; never narrower than one bit so that
  // single-entry configurations still yield legal vector declarations.
  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/row_id_counter.sv
// Nested (filter, channel) row counter: channel is the inner index, filter the outer.
// Latency: new IDs visible the cycle after clr/en; last_row is combinational from the IDs.
// Backpressure: none; advances only when en is asserted by the owner FSM.
//
// Ports: clk/rst (async active-low), clr (return to row 0,0; wins over en),
//        en (advance one row), filter_id/channel_id (current row), last_row.
module row_id_counter #(
  parameter int NUM_FILTERS  = 1,
  parameter int NUM_CHANNELS = 1,
  parameter int FW           = 1,
  parameter int CW           = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [FW-1:0] filter_id,
  output logic [CW-1:0] channel_id,
  output logic          last_row
);

  localparam logic [FW-1:0] F_LAST = FW'(NUM_FILTERS - 1);
  localparam logic [CW-1:0] C_LAST = CW'(NUM_CHANNELS - 1);

  assign last_row = (filter_id == F_LAST) && (channel_id == C_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filter_id  <= '0;
      channel_id <= '0;
    end else if (clr) begin
      filter_id  <= '0;
      channel_id <= '0;
    end else if (en) begin
      if (channel_id == C_LAST) begin
        channel_id <= '0;
        // Wrap after the last row keeps both IDs inside their legal ranges.
        filter_id  <= (filter_id == F_LAST) ? '0 : filter_id + 1'b1;
      end else begin
        channel_id <= channel_id + 1'b1;
      end
    end
  end

endmodule

// File: rtl/filter_row_sched.sv
// Filter weight buffer controller: preloads weight triples, then sequences (filter, channel) rows.
// Latency: preload writes registered (+1 cycle); cmd_run to first fb_load_row is 1 cycle; 3 cycles/row minimum.
// Backpressure: wt_ready high only in PRELOAD; rows wait indefinitely on fb_weight_valid and row_ack.
//
// Ports: clk, rst (async active-low); cmd_preload/cmd_run (one-cycle commands);
//        wt_valid/wt_ready/wt_data (weight source, lanes pe2|pe1|pe0 from MSB);
//        fb_preload_* (buffer write port); fb_load_row/fb_filter_id/fb_channel_id (row request);
//        fb_weight_valid/row_ack (row handshake); busy, preload_done, run_done, err_not_loaded (status).
module filter_row_sched
  import filter_sched_pkg::*;
#(
  parameter  int DATA_WIDTH   = 16,
  parameter  int NUM_FILTERS  = 1,
  parameter  int NUM_CHANNELS = 1,
  parameter  int KERNEL_SIZE  = 3,
  localparam int DEPTH        = NUM_FILTERS * NUM_CHANNELS * KERNEL_SIZE,
  localparam int AW           = clog2_min1(DEPTH),
  localparam int FW           = clog2_min1(NUM_FILTERS),
  localparam int CW           = clog2_min1(NUM_CHANNELS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_preload,
  input  logic                    cmd_run,
  input  logic                    wt_valid,
  output logic                    wt_ready,
  input  logic [3*DATA_WIDTH-1:0] wt_data,
  output logic                    fb_preload_en,
  output logic [AW-1:0]           fb_preload_addr,
  output logic [DATA_WIDTH-1:0]   fb_preload_data_pe0,
  output logic [DATA_WIDTH-1:0]   fb_preload_data_pe1,
  output logic [DATA_WIDTH-1:0]   fb_preload_data_pe2,
  output logic                    fb_load_row,
  output logic [FW-1:0]           fb_filter_id,
  output logic [CW-1:0]           fb_channel_id,
  input  logic                    fb_weight_valid,
  input  logic                    row_ack,
  output logic                    busy,
  output logic                    preload_done,
  output logic                    run_done,
  output logic                    err_not_loaded
);

  localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);

  state_t        state;
  logic [AW-1:0] addr_cnt;
  logic          id_clr;
  logic          id_en;
  logic          last_row;

  assign wt_ready = (state == S_PRELOAD);
  assign busy     = (state != S_IDLE);

  // A run start restarts from row (0,0); preload has priority over a coincident run.
  assign id_clr = (state == S_IDLE) && cmd_run && !cmd_preload && preload_done;
  assign id_en  = (state == S_HOLD) && row_ack;

  row_id_counter #(
    .NUM_FILTERS  (NUM_FILTERS),
    .NUM_CHANNELS (NUM_CHANNELS),
    .FW           (FW),
    .CW           (CW)
  ) u_row_id (
    .clk        (clk),
    .rst        (rst),
    .clr        (id_clr),
    .en         (id_en),
    .filter_id  (fb_filter_id),
    .channel_id (fb_channel_id),
    .last_row   (last_row)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state               <= S_IDLE;
      addr_cnt            <= '0;
      fb_preload_en       <= 1'b0;
      fb_preload_addr     <= '0;
      fb_preload_data_pe0 <= '0;
      fb_preload_data_pe1 <= '0;
      fb_preload_data_pe2 <= '0;
      fb_load_row         <= 1'b0;
      preload_done        <= 1'b0;
      run_done            <= 1'b0;
      err_not_loaded      <= 1'b0;
    end else begin
      // Strobes default low so each is a single-cycle pulse.
      fb_preload_en  <= 1'b0;
      fb_load_row    <= 1'b0;
      run_done       <= 1'b0;
      err_not_loaded <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_preload) begin
            state        <= S_PRELOAD;
            preload_done <= 1'b0;
            addr_cnt     <= '0;
          end else if (cmd_run) begin
            if (preload_done) begin
              state       <= S_LOAD;
              fb_load_row <= 1'b1;
            end else begin
              err_not_loaded <= 1'b1;
            end
          end
        end
        S_PRELOAD: begin
          if (wt_valid) begin
            fb_preload_en       <= 1'b1;
            fb_preload_addr     <= addr_cnt;
            fb_preload_data_pe0 <= wt_data[DATA_WIDTH-1:0];
            fb_preload_data_pe1 <= wt_data[2*DATA_WIDTH-1:DATA_WIDTH];
            fb_preload_data_pe2 <= wt_data[3*DATA_WIDTH-1:2*DATA_WIDTH];
            addr_cnt            <= addr_cnt + 1'b1;
            if (addr_cnt == ADDR_LAST) begin
              state        <= S_IDLE;
              preload_done <= 1'b1;
            end
          end
        end
        // fb_load_row was raised on entry, so LOAD lasts exactly one cycle.
        S_LOAD: state <= S_WAIT_VALID;
        S_WAIT_VALID: begin
          if (fb_weight_valid) state <= S_HOLD;
        end
        S_HOLD: begin
          if (row_ack) begin
            if (last_row) begin
              state    <= S_DONE;
              run_done <= 1'b1;
            end else begin
              state       <= S_LOAD;
              fb_load_row <= 1'b1;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_filter_row_sched.sv
// Directed bench for filter_row_sched with 2 filters x 2 channels x kernel 3 (depth 12).
// Latency: n/a.
// Backpressure: n/a.
module tb_filter_row_sched;

  logic        clk;
  logic        rst;
  logic        cmd_preload;
  logic        cmd_run;
  logic        wt_valid;
  logic        wt_ready;
  logic [47:0] wt_data;
  logic        fb_preload_en;
  logic [3:0]  fb_preload_addr;
  logic [15:0] pe0, pe1, pe2;
  logic        fb_load_row;
  logic [0:0]  fb_filter_id;
  logic [0:0]  fb_channel_id;
  logic        fb_weight_valid;
  logic        row_ack;
  logic        busy;
  logic        preload_done;
  logic        run_done;
  logic        err_not_loaded;

  int checks   = 0;
  int failures = 0;

  filter_row_sched #(
    .DATA_WIDTH   (16),
    .NUM_FILTERS  (2),
    .NUM_CHANNELS (2),
    .KERNEL_SIZE  (3)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .cmd_preload         (cmd_preload),
    .cmd_run             (cmd_run),
    .wt_valid            (wt_valid),
    .wt_ready            (wt_ready),
    .wt_data             (wt_data),
    .fb_preload_en       (fb_preload_en),
    .fb_preload_addr     (fb_preload_addr),
    .fb_preload_data_pe0 (pe0),
    .fb_preload_data_pe1 (pe1),
    .fb_preload_data_pe2 (pe2),
    .fb_load_row         (fb_load_row),
    .fb_filter_id        (fb_filter_id),
    .fb_channel_id       (fb_channel_id),
    .fb_weight_valid     (fb_weight_valid),
    .row_ack             (row_ack),
    .busy                (busy),
    .preload_done        (preload_done),
    .run_done            (run_done),
    .err_not_loaded      (err_not_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic ok, input logic [63:0] obs);
    checks++;
    if (ok !== 1'b1) begin
      failures++;
      $error("FAIL %s observed=%0d", tag, obs);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input int k);
    wt_data = {16'(k + 2000), 16'(k + 1000), 16'(k)};
  endtask

  // Entered in the LOAD cycle; answers valid and ack one cycle after each request.
  task automatic do_row(input int f, input int c);
    chk("row_load_pulse", fb_load_row === 1'b1, 64'(fb_load_row));
    chk("row_filter", 64'(fb_filter_id) === 64'(f), 64'(fb_filter_id));
    chk("row_channel", 64'(fb_channel_id) === 64'(c), 64'(fb_channel_id));
    tick();
    chk("row_load_low", fb_load_row === 1'b0, 64'(fb_load_row));
    fb_weight_valid = 1'b1;
    tick();
    fb_weight_valid = 1'b0;
    chk("row_hold_filter", 64'(fb_filter_id) === 64'(f), 64'(fb_filter_id));
    chk("row_hold_channel", 64'(fb_channel_id) === 64'(c), 64'(fb_channel_id));
    row_ack = 1'b1;
    tick();
    row_ack = 1'b0;
  endtask

  initial begin
    int sent;
    int nwr;

    rst = 1'b0; cmd_preload = 1'b0; cmd_run = 1'b0; wt_valid = 1'b0;
    wt_data = '0; fb_weight_valid = 1'b0; row_ack = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_wt_ready", wt_ready === 1'b0, 64'(wt_ready));
    chk("rst_busy", busy === 1'b0, 64'(busy));
    chk("rst_preload_done", preload_done === 1'b0, 64'(preload_done));
    chk("rst_strobes", {fb_preload_en, fb_load_row, run_done, err_not_loaded} === 4'b0000,
        64'({fb_preload_en, fb_load_row, run_done, err_not_loaded}));
    chk("rst_addr_ids", {fb_preload_addr, fb_filter_id, fb_channel_id} === 6'b0,
        64'({fb_preload_addr, fb_filter_id, fb_channel_id}));
    chk("rst_data", {pe2, pe1, pe0} === 48'b0, 64'({pe2, pe1, pe0}));
    rst = 1'b1;
    tick();

    // cmd_run before any preload is rejected
    cmd_run = 1'b1;
    tick();
    cmd_run = 1'b0;
    chk("early_run_err", err_not_loaded === 1'b1, 64'(err_not_loaded));
    chk("early_run_busy", busy === 1'b0, 64'(busy));
    chk("early_run_load", fb_load_row === 1'b0, 64'(fb_load_row));
    tick();
    chk("early_run_err_pulse", err_not_loaded === 1'b0, 64'(err_not_loaded));
    chk("early_run_load2", fb_load_row === 1'b0, 64'(fb_load_row));

    // Back-to-back preload of 12 beats
    cmd_preload = 1'b1;
    tick();
    cmd_preload = 1'b0;
    chk("pl_busy", busy === 1'b1, 64'(busy));
    chk("pl_wt_ready", wt_ready === 1'b1, 64'(wt_ready));
    for (int k = 0; k < 12; k++) begin
      wt_valid = 1'b1;
      set_beat(k);
      tick();
      chk("pl_en", fb_preload_en === 1'b1, 64'(fb_preload_en));
      chk("pl_addr", 64'(fb_preload_addr) === 64'(k), 64'(fb_preload_addr));
      chk("pl_pe0", 64'(pe0) === 64'(k), 64'(pe0));
      chk("pl_pe1", 64'(pe1) === 64'(k + 1000), 64'(pe1));
      chk("pl_pe2", 64'(pe2) === 64'(k + 2000), 64'(pe2));
      if (k < 11) chk("pl_done_early", preload_done === 1'b0, 64'(preload_done));
    end
    chk("pl_done", preload_done === 1'b1, 64'(preload_done));
    chk("pl_ready_drop", wt_ready === 1'b0, 64'(wt_ready));
    set_beat(99);
    tick();
    wt_valid = 1'b0;
    chk("pl_no_extra", fb_preload_en === 1'b0, 64'(fb_preload_en));
    chk("pl_idle", busy === 1'b0, 64'(busy));

    // Preload with wt_valid toggling 1/0
    cmd_preload = 1'b1;
    tick();
    cmd_preload = 1'b0;
    chk("tg_done_cleared", preload_done === 1'b0, 64'(preload_done));
    sent = 0;
    nwr  = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      wt_valid = ((cyc % 2) == 0) && (sent < 12);
      set_beat(sent);
      tick();
      if (wt_valid) sent++;
      if (fb_preload_en) begin
        chk("tg_addr", 64'(fb_preload_addr) === 64'(nwr), 64'(fb_preload_addr));
        chk("tg_pe0", 64'(pe0) === 64'(nwr), 64'(pe0));
        nwr++;
      end
    end
    wt_valid = 1'b0;
    chk("tg_write_count", nwr == 12, 64'(nwr));
    chk("tg_done", preload_done === 1'b1, 64'(preload_done));

    // Full run of four rows
    cmd_run = 1'b1;
    tick();
    cmd_run = 1'b0;
    chk("run_busy", busy === 1'b1, 64'(busy));
    do_row(0, 0);
    do_row(0, 1);
    do_row(1, 0);
    do_row(1, 1);
    chk("run_done_pulse", run_done === 1'b1, 64'(run_done));
    chk("run_load_none", fb_load_row === 1'b0, 64'(fb_load_row));
    tick();
    chk("run_done_low", run_done === 1'b0, 64'(run_done));
    chk("run_busy_low", busy === 1'b0, 64'(busy));
    chk("run_keep_loaded", preload_done === 1'b1, 64'(preload_done));

    // Simultaneous cmd_preload and cmd_run
    cmd_preload = 1'b1;
    cmd_run     = 1'b1;
    tick();
    cmd_preload = 1'b0;
    cmd_run     = 1'b0;
    chk("both_err", err_not_loaded === 1'b0, 64'(err_not_loaded));
    chk("both_wt_ready", wt_ready === 1'b1, 64'(wt_ready));
    chk("both_load", fb_load_row === 1'b0, 64'(fb_load_row));
    chk("both_done_clr", preload_done === 1'b0, 64'(preload_done));
    for (int k = 0; k < 12; k++) begin
      wt_valid = 1'b1;
      set_beat(k);
      tick();
    end
    wt_valid = 1'b0;
    chk("both_done", preload_done === 1'b1, 64'(preload_done));

    // Reset during HOLD of row (1,0)
    cmd_run = 1'b1;
    tick();
    cmd_run = 1'b0;
    do_row(0, 0);
    do_row(0, 1);
    chk("hr_load", fb_load_row === 1'b1, 64'(fb_load_row));
    tick();
    fb_weight_valid = 1'b1;
    tick();
    fb_weight_valid = 1'b0;
    chk("hr_ids", {fb_filter_id, fb_channel_id} === 2'b10, 64'({fb_filter_id, fb_channel_id}));
    chk("hr_busy", busy === 1'b1, 64'(busy));
    row_ack = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("hr_busy0", busy === 1'b0, 64'(busy));
    chk("hr_done0", preload_done === 1'b0, 64'(preload_done));
    chk("hr_ids0", {fb_filter_id, fb_channel_id} === 2'b00, 64'({fb_filter_id, fb_channel_id}));
    chk("hr_outs0", {wt_ready, fb_preload_en, fb_load_row, run_done, err_not_loaded} === 5'b0,
        64'({wt_ready, fb_preload_en, fb_load_row, run_done, err_not_loaded}));
    chk("hr_addr_data0", {fb_preload_addr, pe2, pe1, pe0} === 52'b0,
        64'({fb_preload_addr, pe2, pe1, pe0}));
    row_ack = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    cmd_run = 1'b1;
    tick();
    cmd_run = 1'b0;
    chk("hr_err", err_not_loaded === 1'b1, 64'(err_not_loaded));
    chk("hr_err_busy", busy === 1'b0, 64'(busy));
    chk("hr_err_load", fb_load_row === 1'b0, 64'(fb_load_row));
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
